// File: rtl/gauss_window_feeder.sv
// gauss_window_feeder
// Builds the TAPS-wide horizontal pixel window for the Gaussian dot-product
// stage. It emits one window per accepted pixel, centred on that pixel.
// The left and right image borders are edge-replicated by default.
// Define GAUSS_WIN_ZERO_PAD_EN to use zero padding at the borders instead.
// Window orientation: out_win[0] is the newest (rightmost) pixel,
// out_win[TAPS-1] is the oldest (leftmost) pixel, and out_win[HALF] is the centre.
module gauss_window_feeder #(
  parameter int DATA_W = 8,
  parameter int TAPS   = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_pix,
  input  logic              in_valid,
  input  logic              in_eol,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_win [TAPS-1:0],
  output logic              out_valid,
  output logic              out_sol,
  output logic              out_eol,
  input  logic              out_ready
);

  localparam int HALF  = (TAPS - 1) / 2;
  localparam int CNT_W = $clog2(HALF + 2);

  // A window is complete once the centre pixel has HALF right neighbours.
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(HALF + 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  filled_reg, filled_next;
  logic [CNT_W-1:0]  lag_reg, lag_next;
  logic              valid_reg, valid_next;
  logic              sol_reg, sol_next;
  logic [DATA_W-1:0] win_reg  [TAPS-1:0];
  logic [DATA_W-1:0] win_next [TAPS-1:0];

  logic              ready_int;
  logic              consume;
  logic              win_load;
  logic              win_shift;
  logic [DATA_W-1:0] shift_pix;
  logic [DATA_W-1:0] border_load;
  logic [DATA_W-1:0] flush_pix;
  logic [CNT_W-1:0]  filled_inc;

  // Border policy: this sets what fills the non-newest taps on the first
  // pixel, and what is shifted in past the end of the line.
`ifdef GAUSS_WIN_ZERO_PAD_EN
  assign border_load = '0;
  assign flush_pix   = '0;
`else
  assign border_load = in_pix;
  assign flush_pix   = win_reg[0];
`endif

  assign consume    = valid_reg & out_ready;
  assign filled_inc = filled_reg + ONE_CNT;

  // Next-state, counter and window-control decode
  always_comb begin
    state_next  = state_reg;
    filled_next = filled_reg;
    lag_next    = lag_reg;
    valid_next  = valid_reg;
    sol_next    = sol_reg;
    win_load    = 1'b0;
    win_shift   = 1'b0;
    shift_pix   = in_pix;
    ready_int   = 1'b0;

    case (state_reg)
      IDLE: begin
        ready_int = 1'b1;
        if (in_valid) begin
          win_load    = 1'b1;
          filled_next = ONE_CNT;
          lag_next    = ONE_CNT;
          state_next  = in_eol ? FLUSH : FILL;
        end
      end

      FILL: begin
        ready_int = 1'b1;
        if (in_valid) begin
          win_shift   = 1'b1;
          filled_next = filled_inc;
          lag_next    = lag_reg + ONE_CNT;
          if (filled_inc == FULL_CNT) begin
            valid_next = 1'b1;
            sol_next   = 1'b1;
            state_next = in_eol ? FLUSH : RUN;
          end else if (in_eol) begin
            state_next = FLUSH;
          end
        end
      end

      RUN: begin
        // A held window blocks new pixels, because shifting would corrupt it.
        ready_int = !valid_reg | out_ready;
        if (in_valid && ready_int) begin
          win_shift  = 1'b1;
          valid_next = 1'b1;
          if (consume) begin
            sol_next = 1'b0;
          end else begin
            lag_next = lag_reg + ONE_CNT;
          end
          if (in_eol) begin
            state_next = FLUSH;
          end
        end else if (consume) begin
          valid_next = 1'b0;
          sol_next   = 1'b0;
          lag_next   = lag_reg - ONE_CNT;
        end
      end

      FLUSH: begin
        shift_pix = flush_pix;
        if (filled_reg != FULL_CNT) begin
          // The line was shorter than HALF+1, so pad the window up to the first centre.
          win_shift   = 1'b1;
          filled_next = filled_inc;
          if (filled_inc == FULL_CNT) begin
            valid_next = 1'b1;
            sol_next   = 1'b1;
          end
        end else if (consume) begin
          sol_next = 1'b0;
          lag_next = lag_reg - ONE_CNT;
          if (lag_reg == ONE_CNT) begin
            valid_next  = 1'b0;
            filled_next = '0;
            state_next  = IDLE;
          end else begin
            win_shift = 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Per-tap next value: load on line start, shift toward the oldest tap, or hold
  generate
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
      if (gi == 0) begin : g_newest
        assign win_next[gi] = win_load  ? in_pix    :
                              win_shift ? shift_pix : win_reg[gi];
      end else begin : g_older
        assign win_next[gi] = win_load  ? border_load :
                              win_shift ? win_reg[gi-1] : win_reg[gi];
      end
      assign out_win[gi] = win_reg[gi];
    end
  endgenerate

  // Control state register, with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      filled_reg <= '0;
      lag_reg    <= '0;
      valid_reg  <= 1'b0;
      sol_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      filled_reg <= filled_next;
      lag_reg    <= lag_next;
      valid_reg  <= valid_next;
      sol_reg    <= sol_next;
    end
  end

  // Window register, which reset clears so that no stale pixels survive
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        win_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < TAPS; i++) begin
        win_reg[i] <= win_next[i];
      end
    end
  end

  assign in_ready  = rst_n & ready_int;
  assign out_valid = valid_reg;
  assign out_sol   = sol_reg;
  // The last window of a line is the one shown while exactly one is owed.
  assign out_eol   = valid_reg & (state_reg == FLUSH) & (lag_reg == ONE_CNT);

endmodule

// File: tb/tb_gauss_window_feeder.sv
// Testbench for gauss_window_feeder (DATA_W=8, TAPS=11).
// Hand-computed window table plus an index-based border model.
// Expectations follow GAUSS_WIN_ZERO_PAD_EN when it is defined.
module tb_gauss_window_feeder;

  localparam int DATA_W = 8;
  localparam int TAPS   = 11;
  localparam int HALF   = 5;
`ifdef GAUSS_WIN_ZERO_PAD_EN
  localparam bit ZP = 1'b1;
`else
  localparam bit ZP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] in_pix;
  logic              in_valid;
  logic              in_eol;
  logic              in_ready;
  logic [DATA_W-1:0] out_win [TAPS-1:0];
  logic              out_valid;
  logic              out_sol;
  logic              out_eol;
  logic              out_ready;

  gauss_window_feeder #(.DATA_W(DATA_W), .TAPS(TAPS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_pix    (in_pix),
    .in_valid  (in_valid),
    .in_eol    (in_eol),
    .in_ready  (in_ready),
    .out_win   (out_win),
    .out_valid (out_valid),
    .out_sol   (out_sol),
    .out_eol   (out_eol),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef logic [10:0][7:0] win_t;

  typedef struct {
    int   test_id;
    int   idx;
    win_t w;
    bit   sol;
    bit   eol;
  } vec_t;

  vec_t tbl [11];

  int   n_checks = 0;
  int   n_errors = 0;

  logic [7:0] line_pix [64];
  int         line_n;
  win_t       cap_w   [64];
  bit         cap_sol [64];
  bit         cap_eol [64];

  task automatic chk(input string name, input logic [87:0] act, input logic [87:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic win_t cur_win();
    win_t w;
    for (int k = 0; k < TAPS; k++) w[k] = out_win[k];
    return w;
  endfunction

  // Expected window computed from pixel positions, not by shifting
  function automatic win_t model_win(input int idx);
    win_t w;
    for (int k = 0; k < TAPS; k++) begin
      int pos;
      pos = idx + HALF - k;
      if (pos < 0)            w[k] = ZP ? 8'h00 : line_pix[0];
      else if (pos >= line_n) w[k] = ZP ? 8'h00 : line_pix[line_n-1];
      else                    w[k] = line_pix[pos];
    end
    return w;
  endfunction

  // Stream line_pix[0..line_n-1], collect windows, and check everything for this line
  task automatic run_line(input bit rnd, input int test_id);
    int   sent, got, cyc;
    bit   stalled, rdy_bad;
    win_t hold_w, cur;
    logic hold_s, hold_e;
    sent = 0; got = 0; cyc = 0; stalled = 0; rdy_bad = 0;
    hold_w = '0; hold_s = 1'b0; hold_e = 1'b0;
    while (got < line_n && cyc < 2000) begin
      in_valid  = (sent < line_n);
      in_pix    = (sent < line_n) ? line_pix[sent] : 8'h00;
      in_eol    = (sent == line_n - 1);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      cur = cur_win();
      if (stalled) begin
        chk("stall_valid", 88'(out_valid), 88'(1));
        chk("stall_win", cur, hold_w);
        chk("stall_flags", 88'({out_sol, out_eol}), 88'({hold_s, hold_e}));
      end
      if (sent == line_n && in_ready) rdy_bad = 1'b1;
      if (out_valid && out_ready) begin
        if (got < 64) begin
          cap_w[got] = cur; cap_sol[got] = out_sol; cap_eol[got] = out_eol;
        end
        $display("test %0d window %0d: centre %0d sol %0d eol %0d", test_id, got, cur[HALF], out_sol, out_eol);
        got++;
      end
      stalled = out_valid && !out_ready;
      hold_w = cur; hold_s = out_sol; hold_e = out_eol;
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; in_eol = 1'b0; out_ready = 1'b1;
    chk($sformatf("t%0d_window_count", test_id), 88'(got), 88'(line_n));
    chk($sformatf("t%0d_in_ready_in_flush", test_id), 88'(rdy_bad), 88'(0));
    for (int i = 0; i < got && i < 64; i++) begin
      chk($sformatf("t%0d_model_win%0d", test_id, i), cap_w[i], model_win(i));
      chk($sformatf("t%0d_flags%0d", test_id, i), 88'({cap_sol[i], cap_eol[i]}),
          88'({i == 0, i == line_n - 1}));
    end
    for (int t = 0; t < 11; t++) begin
      if (tbl[t].test_id == test_id && tbl[t].idx < got) begin
        chk($sformatf("t%0d_table_win%0d", test_id, tbl[t].idx), cap_w[tbl[t].idx], tbl[t].w);
        chk($sformatf("t%0d_table_flags%0d", test_id, tbl[t].idx),
            88'({cap_sol[tbl[t].idx], cap_eol[tbl[t].idx]}), 88'({tbl[t].sol, tbl[t].eol}));
      end
    end
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("t%0d_no_extra_window", test_id), 88'(out_valid), 88'(0));
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    // Hand-computed windows, listed from tap [10] to tap [0]
`ifdef GAUSS_WIN_ZERO_PAD_EN
    tbl[0]  = '{0, 0,  {{5{8'd0}}, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6}, 1, 0};
    tbl[2]  = '{0, 11, {8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12, {5{8'd0}}}, 0, 1};
    tbl[3]  = '{1, 0,  {{5{8'h00}}, 8'h80, {5{8'h00}}}, 1, 1};
    tbl[4]  = '{2, 0,  {{5{8'd0}}, 8'd10, 8'd20, 8'd30, {3{8'd0}}}, 1, 0};
    tbl[5]  = '{2, 1,  {{4{8'd0}}, 8'd10, 8'd20, 8'd30, {4{8'd0}}}, 0, 0};
    tbl[6]  = '{2, 2,  {{3{8'd0}}, 8'd10, 8'd20, 8'd30, {5{8'd0}}}, 0, 1};
    tbl[8]  = '{3, 39, {8'd34, 8'd35, 8'd36, 8'd37, 8'd38, 8'd39, {5{8'd0}}}, 0, 1};
    tbl[9]  = '{4, 0,  {{5{8'd0}}, 8'd100, 8'd101, 8'd102, 8'd103, 8'd104, 8'd105}, 1, 0};
    tbl[10] = '{4, 5,  {8'd100, 8'd101, 8'd102, 8'd103, 8'd104, 8'd105, {5{8'd0}}}, 0, 1};
`else
    tbl[0]  = '{0, 0,  {{6{8'd1}}, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6}, 1, 0};
    tbl[2]  = '{0, 11, {8'd7, 8'd8, 8'd9, 8'd10, 8'd11, {6{8'd12}}}, 0, 1};
    tbl[3]  = '{1, 0,  {11{8'h80}}, 1, 1};
    tbl[4]  = '{2, 0,  {{6{8'd10}}, 8'd20, {4{8'd30}}}, 1, 0};
    tbl[5]  = '{2, 1,  {{5{8'd10}}, 8'd20, {5{8'd30}}}, 0, 0};
    tbl[6]  = '{2, 2,  {{4{8'd10}}, 8'd20, {6{8'd30}}}, 0, 1};
    tbl[8]  = '{3, 39, {8'd34, 8'd35, 8'd36, 8'd37, 8'd38, {6{8'd39}}}, 0, 1};
    tbl[9]  = '{4, 0,  {{6{8'd100}}, 8'd101, 8'd102, 8'd103, 8'd104, 8'd105}, 1, 0};
    tbl[10] = '{4, 5,  {8'd100, 8'd101, 8'd102, 8'd103, 8'd104, {6{8'd105}}}, 0, 1};
`endif
    tbl[1]  = '{0, 5,  {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11}, 0, 0};
    tbl[7]  = '{3, 0,  {{6{8'd0}}, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5}, 1, 0};

    rst_n = 1'b0; in_pix = '0; in_valid = 1'b0; in_eol = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("in_ready_during_reset", 88'(in_ready), 88'(0));
    @(posedge clk);
    @(negedge clk);
    chk("reset_valid_sol_eol", 88'({out_valid, out_sol, out_eol}), 88'(0));
    chk("reset_win", cur_win(), '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 0: ramp 1..12
    line_n = 12;
    for (int i = 0; i < 12; i++) line_pix[i] = 8'(i + 1);
    run_line(1'b0, 0);

    // Test 1: single pixel line
    line_n = 1; line_pix[0] = 8'h80;
    run_line(1'b0, 1);

    // Test 2: three-pixel line
    line_n = 3; line_pix[0] = 8'd10; line_pix[1] = 8'd20; line_pix[2] = 8'd30;
    run_line(1'b0, 2);

    // Test 3: ramp 0..39 with random downstream backpressure
    line_n = 40;
    for (int i = 0; i < 40; i++) line_pix[i] = 8'(i);
    run_line(1'b1, 3);

    // Reset after eight pixels of a line that has no eol
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_pix = 8'(50 + i); in_eol = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("in_ready_mid_reset", 88'(in_ready), 88'(0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midline_reset_valid", 88'(out_valid), 88'(0));
    chk("midline_reset_win", cur_win(), '0);
    @(posedge clk);
    @(negedge clk);
    chk("midline_reset_no_partial", 88'(out_valid), 88'(0));

    // Test 4: a fresh line after the mid-line reset
    line_n = 6;
    for (int i = 0; i < 6; i++) line_pix[i] = 8'(100 + i);
    run_line(1'b0, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
